dma_priority_arb: RTL

DMA_PRIORITY_ARB -- requirements
Module: dma_priority_arb

---
 rtl/dma_priority_arb_pkg.sv | 19 +
 rtl/dma_priority_arb_prio_encode.sv | 33 +++
 rtl/dma_priority_arb.sv | 103 ++++++++++
 3 files changed

// File: rtl/dma_priority_arb_pkg.sv
// Shared definitions for the 4-channel DMA priority arbiter: channel count,
// arbiter state encoding and commandReg bit positions.
package dmaPkg;

  localparam int NCH = 4;

  localparam int CMD_DISABLE   = 2;
  localparam int CMD_ROTATE    = 4;
  localparam int CMD_DREQ_LOW  = 6;
  localparam int CMD_DACK_HIGH = 7;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    GRANT   = 2'd2,
    RELEASE = 2'd3
  } arb_state_e;

endpackage

// File: rtl/dma_priority_arb_prio_encode.sv
// Combinational priority picker: fixed (ch0 first) or rotating starting just
// after the last completed channel.
module dma_prio_encode
  import dmaPkg::*;
(
  input  logic [3:0] eff,
  input  logic       rotate,
  input  logic [1:0] lastCh,
  output logic [1:0] winner,
  output logic       any
);

  logic [1:0] start;
  logic [1:0] idx;
  logic       found;

  always_comb begin
    winner = 2'd0;
    any    = |eff;
    start  = rotate ? (lastCh + 2'd1) : 2'd0;
    idx    = 2'd0;
    found  = 1'b0;
    // Walk the ring from the start position; the first set request wins.
    for (int k = 0; k < NCH; k++) begin
      idx = start + 2'(k);
      if (!found && eff[idx]) begin
        winner = idx;
        found  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/dma_priority_arb.sv
// DMA channel arbiter: qualifies DREQ/software requests, negotiates the bus
// with HRQ/HLDA and holds a non-preemptive grant until done or aborted.
module dma_priority_arb #(
  parameter int NCH = 4
) (
  input  logic           CLK,
  input  logic           RESET,
  input  logic [NCH-1:0] dreq,
  input  logic [7:0]     commandReg,
  input  logic [7:0]     requestReg,
  input  logic [7:0]     maskReg,
  input  logic           hlda,
  input  logic           svcDone,
  output logic           hrq,
  output logic [NCH-1:0] dack,
  output logic           grantValid,
  output logic [1:0]     grantCh
);

  import dmaPkg::*;

  arb_state_e     state_q, state_d;
  logic [1:0]     grant_ch_q, grant_ch_d;
  logic [1:0]     last_ch_q, last_ch_d;
  logic [NCH-1:0] eff;
  logic [1:0]     winner;
  logic           any_req;
  logic           dack_on;

  genvar gi;
  generate
    for (gi = 0; gi < NCH; gi++) begin : g_eff
      assign eff[gi] = (((dreq[gi] ^ commandReg[CMD_DREQ_LOW]) & ~maskReg[gi])
                        | requestReg[gi]) & ~commandReg[CMD_DISABLE];
    end
  endgenerate

  dma_prio_encode u_prio (
    .eff    (eff),
    .rotate (commandReg[CMD_ROTATE]),
    .lastCh (last_ch_q),
    .winner (winner),
    .any    (any_req)
  );

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q    <= IDLE;
      grant_ch_q <= 2'd0;
      last_ch_q  <= 2'd3;
    end else begin
      state_q    <= state_d;
      grant_ch_q <= grant_ch_d;
      last_ch_q  <= last_ch_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    grant_ch_d = grant_ch_q;
    last_ch_d  = last_ch_q;
    case (state_q)
      IDLE: begin
        if (any_req) state_d = REQ;
      end
      REQ: begin
        if (!any_req) begin
          state_d = IDLE;
        end else if (hlda) begin
          state_d    = GRANT;
          grant_ch_d = winner;
        end
      end
      GRANT: begin
        // Completion wins over a simultaneous hlda drop.
        if (svcDone) begin
          state_d   = RELEASE;
          last_ch_d = grant_ch_q;
        end else if (!hlda) begin
          state_d = RELEASE;
        end
      end
      RELEASE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign hrq        = (state_q == REQ) || (state_q == GRANT);
  assign grantValid = (state_q == GRANT);
  assign grantCh    = grant_ch_q;
  assign dack_on    = commandReg[CMD_DACK_HIGH];

  generate
    for (gi = 0; gi < NCH; gi++) begin : g_dack
      assign dack[gi] = (grantValid && (grant_ch_q == 2'(gi))) ? dack_on : ~dack_on;
    end
  endgenerate

  logic unused_bits;
  assign unused_bits = ^{commandReg[5], commandReg[3], commandReg[1:0],
                         requestReg[7:NCH], maskReg[7:NCH]};

endmodule
